// File: rtl/btn_press_classifier_if.sv
// ============================================================================
// Module      : btn_press_classifier_if
// Description : Button-in / event-pulse-out bundle for btn_press_classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btn_press_classifier_if;
    logic tick;
    logic db_btn;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic double_pulse;
    logic held;
    logic repeat_pulse;

    modport master (
        output tick,
        output db_btn,
        input  press_pulse,
        input  short_pulse,
        input  long_pulse,
        input  double_pulse,
        input  held,
        input  repeat_pulse
    );

    modport slave (
        input  tick,
        input  db_btn,
        output press_pulse,
        output short_pulse,
        output long_pulse,
        output double_pulse,
        output held,
        output repeat_pulse
    );
endinterface

`default_nettype wire

// File: rtl/btn_press_classifier.sv
// ============================================================================
// Module      : btn_press_classifier
// Description : Classifies debounced presses as short/long/double and emits
//               one-clk event pulses. Define BTN_REPEAT_EN for auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_press_classifier #(
    parameter int LONG_TICKS   = 100,
    parameter int DOUBLE_TICKS = 25,
    parameter int REPEAT_TICKS = 10
) (
    input  wire logic               clk,
    input  wire logic               reset,
    btn_press_classifier_if.slave   bus
);

    localparam int c_MAX_LD  = (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
    localparam int c_CNT_MAX = (c_MAX_LD > REPEAT_TICKS) ? c_MAX_LD : REPEAT_TICKS;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT   = {c_CNT_W{1'b1}};
    localparam logic [c_CNT_W-1:0] c_LONG_LAST = c_CNT_W'(LONG_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_DBL_LAST  = c_CNT_W'(DOUBLE_TICKS - 1);
`ifdef BTN_REPEAT_EN
    localparam logic [c_CNT_W-1:0] c_REP_LAST  = c_CNT_W'(REPEAT_TICKS - 1);
`endif

    localparam logic [2:0] c_IDLE           = 3'd0;
    localparam logic [2:0] c_PRESSED        = 3'd1;
    localparam logic [2:0] c_LONG_HELD      = 3'd2;
    localparam logic [2:0] c_WAIT_SECOND    = 3'd3;
    localparam logic [2:0] c_SECOND_PRESSED = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               prev_q;
    logic               held_q;
    logic               press_q, press_d;
    logic               short_q, short_d;
    logic               long_q, long_d;
    logic               double_q, double_d;
    logic               rise_w, fall_w;

    assign rise_w =  bus.db_btn & ~prev_q;
    assign fall_w = ~bus.db_btn &  prev_q;

`ifdef BTN_REPEAT_EN
    logic repeat_q, repeat_d;
`endif

    // Every transition below clears cnt, which also drops a coincident tick.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (bus.tick && (cnt_q != c_CNT_SAT)) ? (cnt_q + c_CNT_ONE) : cnt_q;
        press_d  = rise_w;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
`ifdef BTN_REPEAT_EN
        repeat_d = 1'b0;
`endif
        case (state_q)
            c_IDLE: begin
                if (rise_w) begin
                    state_d = c_PRESSED;
                    cnt_d   = '0;
                end
            end
            c_PRESSED: begin
                if (fall_w) begin
                    state_d = c_WAIT_SECOND;
                    cnt_d   = '0;
                end else if (bus.tick && (cnt_q == c_LONG_LAST)) begin
                    state_d = c_LONG_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end
            end
            c_LONG_HELD: begin
                if (fall_w) begin
                    state_d = c_IDLE;
                    cnt_d   = '0;
                end
`ifdef BTN_REPEAT_EN
                else if (bus.tick && (cnt_q == c_REP_LAST)) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end
`endif
            end
            c_WAIT_SECOND: begin
                if (rise_w) begin
                    state_d  = c_SECOND_PRESSED;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end else if (bus.tick && (cnt_q == c_DBL_LAST)) begin
                    state_d = c_IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end
            end
            c_SECOND_PRESSED: begin
                if (fall_w) begin
                    state_d = c_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = c_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // prev resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= c_IDLE;
            cnt_q    <= '0;
            prev_q   <= 1'b1;
            held_q   <= 1'b0;
            press_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= bus.db_btn;
            held_q   <= bus.db_btn;
            press_q  <= press_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
        end
    end

`ifdef BTN_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
    assign bus.repeat_pulse = repeat_q;
`else
    assign bus.repeat_pulse = 1'b0;
`endif

    assign bus.press_pulse  = press_q;
    assign bus.short_pulse  = short_q;
    assign bus.long_pulse   = long_q;
    assign bus.double_pulse = double_q;
    assign bus.held         = held_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_press_classifier.sv
// ============================================================================
// Module      : tb_btn_press_classifier
// Description : Directed bench for btn_press_classifier (LONG=4, DOUBLE=3, REPEAT=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_press_classifier;

`ifdef BTN_REPEAT_EN
    localparam logic c_REP = 1'b1;
`else
    localparam logic c_REP = 1'b0;
`endif

    typedef struct packed {
        logic       btn;
        logic       tk;
        logic [5:0] exp;   // {press, short, long, double, held, repeat}
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t tv[$];

    btn_press_classifier_if bus ();

    btn_press_classifier #(
        .LONG_TICKS   (4),
        .DOUBLE_TICKS (3),
        .REPEAT_TICKS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic add(input logic b, input logic t, input logic [5:0] e);
        vec_t v;
        v.btn = b;
        v.tk  = t;
        v.exp = e;
        tv.push_back(v);
    endtask

    task automatic step(input logic b, input logic t);
        @(negedge clk);
        bus.db_btn = b;
        bus.tick   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [5:0] exp);
        logic [5:0] got;
        got = {bus.press_pulse, bus.short_pulse, bus.long_pulse,
               bus.double_pulse, bus.held, bus.repeat_pulse};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, got, exp);
        end
    endtask

    // Nine quiet clocks then one tick clock; quiet clocks must show only held.
    task automatic tick_period(input logic b, input string nm, input logic [5:0] exp_tick);
        for (int q = 0; q < 9; q++) begin
            step(b, 1'b0);
            chk({nm, "_quiet"}, {4'b0000, b, 1'b0});
        end
        step(b, 1'b1);
        chk(nm, exp_tick);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        bus.db_btn = 1'b1;
        bus.tick   = 1'b0;

        // Held button during and after reset: never a press.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 6'b000000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, (i % 10) == 9);
            chk("held_thru_reset", 6'b000010);
        end

        // Short press.
        add(0, 0, 6'b000000);
        add(1, 0, 6'b100010);
        add(1, 1, 6'b000010);
        add(1, 1, 6'b000010);
        add(0, 0, 6'b000000);
        add(0, 1, 6'b000000);
        add(0, 1, 6'b000000);
        add(0, 1, 6'b010000);
        add(0, 1, 6'b000000);
        // Double press, no long while second press is held, no short after.
        add(1, 0, 6'b100010);
        add(1, 1, 6'b000010);
        add(0, 0, 6'b000000);
        add(0, 1, 6'b000000);
        add(1, 0, 6'b100110);
        add(1, 1, 6'b000010);
        add(1, 1, 6'b000010);
        add(1, 1, 6'b000010);
        add(1, 1, 6'b000010);
        add(0, 0, 6'b000000);
        add(0, 1, 6'b000000);
        add(0, 1, 6'b000000);
        add(0, 1, 6'b000000);
        // Rise coincident with tick: entry tick ignored, long after 4 more ticks.
        add(1, 1, 6'b100010);
        add(1, 1, 6'b000010);
        add(1, 1, 6'b000010);
        add(1, 1, 6'b000010);
        add(1, 1, 6'b001010);
        add(1, 1, 6'b000010);
        add(1, 1, {5'b00001, c_REP});
        add(0, 1, 6'b000000);
        add(0, 1, 6'b000000);
        add(0, 1, 6'b000000);
        add(0, 1, 6'b000000);
        // Fall beats tick on the would-be long tick; short follows.
        add(1, 0, 6'b100010);
        add(1, 1, 6'b000010);
        add(1, 1, 6'b000010);
        add(1, 1, 6'b000010);
        add(0, 1, 6'b000000);
        add(0, 1, 6'b000000);
        add(0, 1, 6'b000000);
        add(0, 1, 6'b010000);
        // Rise beats tick on the last tick of the double window.
        add(1, 0, 6'b100010);
        add(0, 0, 6'b000000);
        add(0, 1, 6'b000000);
        add(0, 1, 6'b000000);
        add(1, 1, 6'b100110);
        add(0, 0, 6'b000000);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].btn, tv[i].tk);
            chk($sformatf("vec%0d", i), tv[i].exp);
        end

        // Hold 10 ticks: long at tick 4, repeats at 6, 8, 10 when enabled.
        step(1'b1, 1'b0);
        chk("hold_press", 6'b100010);
        for (int k = 1; k <= 10; k++) begin
            tick_period(1'b1, $sformatf("hold_tick%0d", k),
                        {2'b00, (k == 4), 1'b0, 1'b1,
                         c_REP && (k > 4) && (((k - 4) % 2) == 0)});
        end
        step(1'b0, 1'b0);
        chk("hold_release", 6'b000000);
        for (int k = 1; k <= 5; k++) begin
            tick_period(1'b0, $sformatf("after_long%0d", k), 6'b000000);
        end

        // Reset mid-hold at tick 2, button still held afterwards.
        step(1'b1, 1'b1);
        chk("rst_press", 6'b100010);
        tick_period(1'b1, "rst_tick1", 6'b000010);
        tick_period(1'b1, "rst_tick2", 6'b000010);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_reset", 6'b000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick_period(1'b1, $sformatf("post_rst%0d", k), 6'b000010);
        end
        step(1'b0, 1'b0);
        chk("post_rst_fall", 6'b000000);
        step(1'b1, 1'b0);
        chk("post_rst_rise", 6'b100010);
        step(1'b0, 1'b0);
        chk("post_rst_rel", 6'b000000);
        tick_period(1'b0, "post_rst_w1", 6'b000000);
        tick_period(1'b0, "post_rst_w2", 6'b000000);
        tick_period(1'b0, "post_rst_short", 6'b010000);
        step(1'b0, 1'b0);
        chk("short_one_clk", 6'b000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
